fifo_reader: RTL

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_reader.sv | 119 +++++++++++
 1 files changed

// File: rtl/fifo_reader.sv
// fifo_reader: pulls words out of a synchronous FIFO (one-cycle registered
// read data) and presents them on a valid/ready stream.
//
// Ports
//   clk         single clock, rising edge
//   rst         synchronous active-high reset
//   enable      high = issue FIFO reads; low = stop reading, drain what is fetched
//   fifo_empty  upstream FIFO empty flag
//   fifo_rd_cs  FIFO chip select (same as fifo_rd_en)
//   fifo_rd_en  FIFO read strobe, one pulse per word
//   fifo_data   FIFO read data, valid the cycle after fifo_rd_en
//   m_data      stream data (oldest buffered word)
//   m_valid     stream valid
//   m_ready     stream ready
//   busy        a word is buffered or in flight
//   word_cnt    words accepted on the stream since reset (wraps)
//
// State | meaning
// IDLE  | nothing buffered, nothing in flight
// FILL  | one read in flight, buffer empty
// STREAM| at least one word buffered, m_valid high
module fifo_reader #(
   parameter int DATA_WIDTH = 8,
   parameter int CNT_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  enable,
   input  logic                  fifo_empty,
   output logic                  fifo_rd_cs,
   output logic                  fifo_rd_en,
   input  logic [DATA_WIDTH-1:0] fifo_data,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic                  busy,
   output logic [CNT_WIDTH-1:0]  word_cnt
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL   = 2'd1,
      STREAM = 2'd2
   } state_t;

   state_t                state_q, state_d;
   logic [1:0]            occ_q, occ_d;
   logic                  pend_q, pend_d;
   logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
   logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
   logic [CNT_WIDTH-1:0]  cnt_q, cnt_d;

   logic                  pop;
   logic                  rd_en;
   logic [1:0]            fill;

   // Outputs are forced low while rst is high so nothing leaks out during
   // the reset cycle, even before the first reset edge has cleared state.
   assign m_valid    = !rst && (state_q == STREAM);
   assign busy       = !rst && (state_q != IDLE);
   assign m_data     = buf0_q;
   assign fifo_rd_en = rd_en;
   assign fifo_rd_cs = rd_en;
   assign word_cnt   = cnt_q;

   always_comb begin
      pop    = m_valid && m_ready;
      // occ + pend never exceeds 2: a read is only issued into the last
      // free slot when a pop frees one at the same edge.
      fill   = occ_q + {1'b0, pend_q};
      rd_en  = !rst && enable && !fifo_empty &&
               ((fill < 2'd2) || ((fill == 2'd2) && pop));

      occ_d  = occ_q + {1'b0, pend_q} - {1'b0, pop};
      pend_d = rd_en;
      cnt_d  = cnt_q + {{(CNT_WIDTH-1){1'b0}}, pop};

      buf0_d = buf0_q;
      buf1_d = buf1_q;
      if (pend_q && !pop) begin
         if (occ_q == 2'd0) buf0_d = fifo_data;
         else               buf1_d = fifo_data;
      end else if (!pend_q && pop) begin
         buf0_d = buf1_q;
      end else if (pend_q && pop) begin
         // Capture and pop together: the arriving word lands behind
         // whatever survives the pop.
         if (occ_q == 2'd1) begin
            buf0_d = fifo_data;
         end else begin
            buf0_d = buf1_q;
            buf1_d = fifo_data;
         end
      end

      if (occ_d != 2'd0)  state_d = STREAM;
      else if (pend_d)    state_d = FILL;
      else                state_d = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         occ_q   <= 2'd0;
         pend_q  <= 1'b0;
         buf0_q  <= '0;
         buf1_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         occ_q   <= occ_d;
         pend_q  <= pend_d;
         buf0_q  <= buf0_d;
         buf1_q  <= buf1_d;
         cnt_q   <= cnt_d;
      end
   end

endmodule
